// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide execute unit:
// RISC-V M-extension op codes and the sequencer states.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiplier/divider: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, with sign fix-up applied when the result is presented.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid,
  input  logic [2:0]          op,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [4:0]          rdn_in,
  input  logic                flush,
  output logic                stall,
  output logic                done,
  output logic [WordSize-1:0] result,
  output logic [4:0]          rdn
);

  localparam int CW = $clog2(WordSize + 1);
  localparam logic [WordSize-1:0] MOST_NEG = {1'b1, {(WordSize-1){1'b0}}};

  state_e              r_state;
  logic [CW-1:0]       r_cnt;
  op_e                 r_op;
  logic                r_neg;
  logic [WordSize-1:0] r_hi;
  logic [WordSize-1:0] r_lo;
  logic [WordSize-1:0] r_mcand;
  logic [WordSize-1:0] r_result;
  logic [4:0]          r_rdn_cap;
  logic [4:0]          r_rdn;

  op_e                 w_op;
  logic                w_accept;
  logic                w_is_div;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic                w_neg;
  logic                w_div0;
  logic                w_ovf;
  logic [WordSize-1:0] w_a_mag;
  logic [WordSize-1:0] w_b_mag;
  logic                w_calc_div;
  logic [WordSize:0]   w_sum;
  logic [WordSize:0]   w_shift;
  logic                w_ge;
  logic [WordSize-1:0] w_sub;
  logic [2*WordSize-1:0] w_prod_c;
  logic [WordSize-1:0] w_quo_c;
  logic [WordSize-1:0] w_rem_c;
  logic [WordSize-1:0] w_final;

  // Operand decode at acceptance
  assign w_op       = op_e'(op);
  assign w_accept   = (r_state == ST_IDLE) && valid && !flush;
  assign w_is_div   = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign w_a_signed = w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign w_b_signed = w_op inside {OP_MULH, OP_DIV, OP_REM};
  assign w_a_neg    = w_a_signed && a[WordSize-1];
  assign w_b_neg    = w_b_signed && b[WordSize-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  assign w_div0     = w_is_div && (b == '0);
  assign w_ovf      = (w_op inside {OP_DIV, OP_REM}) && (a == MOST_NEG) && (b == '1);

  // Remainder sign follows the dividend; quotient/product sign is the XOR of operand signs
  always_comb begin
    w_neg = 1'b0;
    unique case (w_op)
      OP_MULH, OP_DIV: w_neg = w_a_neg ^ w_b_neg;
      OP_MULHSU, OP_REM: w_neg = w_a_neg;
      default:         w_neg = 1'b0;
    endcase
  end

  // Shared datapath: {r_hi, r_lo} is the product or {remainder, quotient}
  assign w_calc_div = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_shift    = {r_hi, r_lo[WordSize-1]};
  assign w_ge       = w_shift >= {1'b0, r_mcand};
  assign w_sub      = w_shift[WordSize-1:0] - r_mcand;

  assign w_prod_c = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo_c  = r_neg ? -r_lo : r_lo;
  assign w_rem_c  = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_final = '0;
    unique case (r_op)
      OP_MUL:                       w_final = w_prod_c[WordSize-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_c[2*WordSize-1:WordSize];
      OP_DIV, OP_DIVU:              w_final = w_quo_c;
      default:                      w_final = w_rem_c;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_neg     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_result  <= '0;
      r_rdn_cap <= '0;
      r_rdn     <= '0;
    end else begin
      if (r_state == ST_DONE) begin
        r_result <= w_final;
        r_rdn    <= r_rdn_cap;
      end
      if (flush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (valid) begin
              r_op      <= w_op;
              r_rdn_cap <= rdn_in;
              if (w_div0) begin
                r_hi    <= a;
                r_lo    <= '1;
                r_neg   <= 1'b0;
                r_state <= ST_DONE;
              end else if (w_ovf) begin
                r_hi    <= '0;
                r_lo    <= a;
                r_neg   <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_hi    <= '0;
                r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                r_mcand <= w_is_div ? w_b_mag : w_a_mag;
                r_neg   <= w_neg;
                r_cnt   <= CW'(WordSize);
                r_state <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            if (w_calc_div) begin
              r_hi <= w_ge ? w_sub : w_shift[WordSize-1:0];
              r_lo <= {r_lo[WordSize-2:0], w_ge};
            end else begin
              r_hi <= w_sum[WordSize:1];
              r_lo <= {w_sum[0], r_lo[WordSize-1:1]};
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state <= ST_DONE;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Result is shown live in DONE, then held from the registered copy
  assign done   = (r_state == ST_DONE);
  assign result = done ? w_final : r_result;
  assign rdn    = done ? r_rdn_cap : r_rdn;
  assign stall  = rstn && (w_accept || (r_state == ST_CALC));

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter WordSize, default 32, datapath width of operands and result.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock, all state updates on posedge
  rstn  input  1  asynchronous active-low reset
  valid  input  1  ID/EX stage holds a mul/div instruction
  op  input  3  operation code from muldiv_pkg
  a  input  WordSize  operand A (rs1 value from ID/EX)
  b  input  WordSize  operand B (rs2 value from ID/EX)
  rdn_in  input  5  destination register number
  flush  input  1  abort any in-progress operation
  stall  output  1  hold ID/EX and earlier stages
  done  output  1  result valid, one-cycle pulse
  result  output  WordSize  operation result
  rdn  output  5  destination register for result

Function
REQ-003 SHALL support op codes 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, with RISC-V M-extension semantics.
REQ-004 SHALL implement FSM states IDLE, CALC, DONE.
REQ-005 IDLE: when valid=1 and flush=0, SHALL capture a, b, op and rdn_in, then go to CALC; the step counter loads WordSize.
REQ-006 CALC: SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, on magnitudes; the counter decrements each cycle.
REQ-007 CALC SHALL last exactly WordSize cycles, then go to DONE.
REQ-008 DONE: SHALL apply the sign correction, assert done=1 for exactly one cycle, drive result and rdn, then return to IDLE.
REQ-009 Acceptance cycle T SHALL give done at cycle T+WordSize+1 (T+33 for WordSize=32).
REQ-010 stall SHALL equal (IDLE and valid and not flush) or CALC; stall SHALL be 0 in DONE, so ID/EX advances in the same cycle the result is presented.
REQ-011 valid SHALL be ignored in CALC and DONE.
REQ-012 MUL SHALL return the low WordSize bits of the product; MULH/MULHSU/MULHU SHALL return the high WordSize bits (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-013 Divide by zero: quotient SHALL be all ones, remainder SHALL be a.
REQ-014 Signed overflow (a = most negative value, b = -1, DIV/REM): quotient SHALL be a, remainder SHALL be 0.
REQ-015 Divide by zero and signed overflow SHALL bypass CALC (IDLE to DONE), with done at T+1.
REQ-016 REM sign SHALL follow the dividend; DIV quotient SHALL be negated when the operand signs differ.
REQ-017 flush=1 in any state SHALL force IDLE on the next edge with no done pulse; flush has priority over acceptance.
REQ-018 result and rdn SHALL hold their last values while done=0.

Reset
REQ-019 rstn low SHALL asynchronously force state IDLE, counter 0, done 0, result 0, rdn 0, and clear all internal operand/accumulator registers.
REQ-020 stall SHALL be 0 while rstn is low.
REQ-021 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL appear after release.

Structure
REQ-022 Package muldiv_pkg SHALL hold the op enum (3-bit) and the FSM state enum; the WordSize default stays a module parameter.
REQ-023 SHALL be a single module with one shared accumulator/shift datapath; no sub-module.

Verification
REQ-024 MUL a=7, b=-3 -> done at T+33, result 0xFFFFFFEB, rdn matches rdn_in; stall high T..T+32.
REQ-025 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH of the same operands -> 0x00000000.
REQ-026 DIV a=-7, b=2 -> result 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14.
REQ-027 DIV a=5, b=0 -> done at T+1, result 0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV a=0x80000000, b=-1 -> 0x80000000, done at T+1.
REQ-028 flush at T+10 of a DIVU -> IDLE next cycle, no done pulse, stall 0; the next valid op completes correctly.
REQ-029 rstn pulsed low at T+5 of a MUL -> all outputs 0 immediately; no done pulse after release.
